// File: rtl/carrd_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// carrd_issue_ctrl_pkg
// Shared types and helpers for the vector issue controller.
//   fu_idx_e      : functional-unit index (lanes, reduction, slide, load/store)
//   issue_entry_t : one pre-decoded vector instruction as held in the issue FIFO
//   grp_mask      : register-group bitmask for a base vreg and a group span
// ---------------------------------------------------------------------------
package carrd_issue_ctrl_pkg;

    localparam int INSTR_W   = 32;
    localparam int FU_IDX_W  = 2;
    localparam int REG_IDX_W = 5;
    localparam int MASK_W    = 32;

    typedef enum logic [FU_IDX_W-1:0] {
        FU_LANES = 2'd0,
        FU_RED   = 2'd1,
        FU_SLDU  = 2'd2,
        FU_LSU   = 2'd3
    } fu_idx_e;

    typedef struct packed {
        logic [INSTR_W-1:0]   instr;
        logic [FU_IDX_W-1:0]  fu;
        logic                 drain;
        logic [REG_IDX_W-1:0] vd;
        logic [REG_IDX_W-1:0] vs1;
        logic [REG_IDX_W-1:0] vs2;
        logic                 use_vs1;
        logic                 use_vs2;
        logic                 wr_vd;
        logic [2:0]           nregs;
    } issue_entry_t;

    // Bits base..base+n-1 of the vreg file. Any span other than 2 or 4 counts
    // as a single register. The left shift drops bits past the top vreg, so a
    // group near the end is truncated rather than wrapped to v0.
    function automatic logic [MASK_W-1:0] grp_mask(input logic [REG_IDX_W-1:0] base,
                                                   input logic [2:0]           n);
        logic [MASK_W-1:0] span;
        case (n)
            3'd2:    span = MASK_W'(32'h3);
            3'd4:    span = MASK_W'(32'hF);
            default: span = MASK_W'(32'h1);
        endcase
        return span << base;
    endfunction

endpackage

// File: rtl/carrd_issue_fifo.sv
// ---------------------------------------------------------------------------
// carrd_issue_fifo
// Synchronous FIFO of issue entries with occupancy count.
//   clk, rst  : clock and synchronous active-high reset
//   i_push    : write i_entry (ignored while full)
//   i_pop     : drop the head entry (ignored while empty)
//   o_head    : current head entry, valid when !o_empty
//   o_count   : number of stored entries (0..DEPTH)
//   o_full    : count == DEPTH
//   o_empty   : count == 0
// ---------------------------------------------------------------------------
module carrd_issue_fifo
    import carrd_issue_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  issue_entry_t     i_entry,
    input  logic             i_pop,
    output issue_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    issue_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Pointers are power-of-two wide so they wrap on their own. The count
    // only moves when exactly one of push/pop happens; storage needs no reset
    // because nothing reads it while the count says empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_entry;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/carrd_issue_ctrl.sv
// ---------------------------------------------------------------------------
// carrd_issue_ctrl
// In-order issue controller between the scalar core's instruction port and
// the vector functional units. Queues pre-decoded instructions, tracks which
// FU is busy and which vregs have a pending write, and issues the head entry
// once its FU is idle and it has no RAW/WAW hazard. Drain (vconfig/fence)
// entries wait for everything to go idle and then pulse iss_drain.
//   clk, rst                      : clock, synchronous active-high reset
//   enq_valid/enq_ready           : enqueue handshake
//   enq_instr..enq_nregs          : pre-decoded instruction fields
//   fu_done                       : per-FU one-cycle completion pulses
//   iss_valid/iss_instr           : one-hot issue pulse with instruction word
//   iss_drain                     : pulse when a drain entry retires
//   sb_busy                       : vregs with a write in flight
//   q_count                       : FIFO occupancy
//   idle                          : nothing queued, nothing in flight
//   err_spurious                  : sticky, fu_done seen for an idle FU
// ---------------------------------------------------------------------------
module carrd_issue_ctrl
    import carrd_issue_ctrl_pkg::*;
#(
    parameter  int NUM_FU      = 4,
    parameter  int QUEUE_DEPTH = 4,
    parameter  int NUM_VREGS   = 32,
    localparam int FU_W        = $clog2(NUM_FU),
    localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [31:0]          enq_instr,
    input  logic [FU_W-1:0]      enq_fu,
    input  logic                 enq_drain,
    input  logic [4:0]           enq_vd,
    input  logic [4:0]           enq_vs1,
    input  logic [4:0]           enq_vs2,
    input  logic                 enq_use_vs1,
    input  logic                 enq_use_vs2,
    input  logic                 enq_wr_vd,
    input  logic [2:0]           enq_nregs,
    input  logic [NUM_FU-1:0]    fu_done,
    output logic [NUM_FU-1:0]    iss_valid,
    output logic [31:0]          iss_instr,
    output logic                 iss_drain,
    output logic [NUM_VREGS-1:0] sb_busy,
    output logic [CNT_W-1:0]     q_count,
    output logic                 idle,
    output logic                 err_spurious
);

    issue_entry_t         w_enqEntry;
    issue_entry_t         w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_pop;
    logic                 w_canIssue;

    logic [NUM_VREGS-1:0] w_vdGrp;
    logic [NUM_VREGS-1:0] w_vs1Grp;
    logic [NUM_VREGS-1:0] w_vs2Grp;
    logic [NUM_VREGS-1:0] w_vdMask;
    logic [NUM_FU-1:0]    w_issOneHot;
    logic [NUM_FU-1:0]    w_retire;
    logic                 w_spurious;
    logic [NUM_VREGS-1:0] w_clearMask;
    logic [NUM_FU-1:0]    w_fuBusyNext;
    logic [NUM_VREGS-1:0] w_sbBusyNext;

    logic [NUM_FU-1:0]    r_fuBusy;
    logic [NUM_VREGS-1:0] r_vdMask [NUM_FU];
    logic [NUM_VREGS-1:0] r_sbBusy;
    logic [NUM_FU-1:0]    r_issValid;
    logic [INSTR_W-1:0]   r_issInstr;
    logic                 r_issDrain;
    logic                 r_errSpurious;

    assign w_enqEntry = '{
        instr:   enq_instr,
        fu:      FU_IDX_W'(enq_fu),
        drain:   enq_drain,
        vd:      enq_vd,
        vs1:     enq_vs1,
        vs2:     enq_vs2,
        use_vs1: enq_use_vs1,
        use_vs2: enq_use_vs2,
        wr_vd:   enq_wr_vd,
        nregs:   enq_nregs
    };

    carrd_issue_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (enq_valid),
        .i_entry (w_enqEntry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_vdGrp     = NUM_VREGS'(grp_mask(w_head.vd,  w_head.nregs));
    assign w_vs1Grp    = NUM_VREGS'(grp_mask(w_head.vs1, w_head.nregs));
    assign w_vs2Grp    = NUM_VREGS'(grp_mask(w_head.vs2, w_head.nregs));
    assign w_vdMask    = w_head.wr_vd ? w_vdGrp : '0;
    assign w_issOneHot = NUM_FU'(1) << w_head.fu;

    // Issue decision for the head entry. Only registered busy/scoreboard state
    // is consulted, so a done pulse frees resources one cycle later rather
    // than bypassing into this check.
    always_comb begin
        w_canIssue = 1'b0;
        if (w_head.drain) begin
            w_canIssue = (r_fuBusy == '0) && (r_sbBusy == '0);
        end else begin
            w_canIssue = !r_fuBusy[w_head.fu]
                      && !(w_head.use_vs1 && ((w_vs1Grp & r_sbBusy) != '0))
                      && !(w_head.use_vs2 && ((w_vs2Grp & r_sbBusy) != '0))
                      && !(w_head.wr_vd   && ((w_vdGrp  & r_sbBusy) != '0));
        end
    end

    assign w_pop      = !w_empty && w_canIssue;
    assign w_retire   = fu_done & r_fuBusy;
    assign w_spurious = |(fu_done & ~r_fuBusy);

    // Next busy and scoreboard state. Retirements clear first, then a new
    // issue sets, so a retire and an issue in the same cycle both land.
    always_comb begin
        w_clearMask = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_retire[i]) begin
                w_clearMask = w_clearMask | r_vdMask[i];
            end
        end
        w_fuBusyNext = r_fuBusy & ~w_retire;
        w_sbBusyNext = r_sbBusy & ~w_clearMask;
        if (w_pop && !w_head.drain) begin
            w_fuBusyNext = w_fuBusyNext | w_issOneHot;
            w_sbBusyNext = w_sbBusyNext | w_vdMask;
        end
    end

    // All controller state. Issue outputs are single-cycle pulses; the
    // instruction word simply holds whatever was last issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fuBusy      <= '0;
            r_sbBusy      <= '0;
            r_issValid    <= '0;
            r_issInstr    <= '0;
            r_issDrain    <= 1'b0;
            r_errSpurious <= 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_vdMask[i] <= '0;
            end
        end else begin
            r_issValid <= '0;
            r_issDrain <= 1'b0;
            r_fuBusy   <= w_fuBusyNext;
            r_sbBusy   <= w_sbBusyNext;
            if (w_spurious) begin
                r_errSpurious <= 1'b1;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_retire[i]) begin
                    r_vdMask[i] <= '0;
                end
            end
            if (w_pop) begin
                r_issInstr <= w_head.instr;
                if (w_head.drain) begin
                    r_issDrain <= 1'b1;
                end else begin
                    r_issValid          <= w_issOneHot;
                    r_vdMask[w_head.fu] <= w_vdMask;
                end
            end
        end
    end

    assign enq_ready    = !w_full;
    assign iss_valid    = r_issValid;
    assign iss_instr    = r_issInstr;
    assign iss_drain    = r_issDrain;
    assign sb_busy      = r_sbBusy;
    assign q_count      = w_count;
    assign idle         = w_empty && (r_fuBusy == '0) && (r_sbBusy == '0);
    assign err_spurious = r_errSpurious;

endmodule

// File: tb/tb_carrd_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_carrd_issue_ctrl
// Directed self-checking bench for carrd_issue_ctrl. Expected issues are
// queued when an instruction is accepted and compared in order whenever the
// DUT pulses iss_valid or iss_drain; timing and scoreboard state are checked
// at fixed points in the directed sequence.
// ---------------------------------------------------------------------------
module tb_carrd_issue_ctrl;
    import carrd_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_instr;
    logic [1:0]  enq_fu;
    logic        enq_drain;
    logic [4:0]  enq_vd;
    logic [4:0]  enq_vs1;
    logic [4:0]  enq_vs2;
    logic        enq_use_vs1;
    logic        enq_use_vs2;
    logic        enq_wr_vd;
    logic [2:0]  enq_nregs;
    logic [3:0]  fu_done;
    logic [3:0]  iss_valid;
    logic [31:0] iss_instr;
    logic        iss_drain;
    logic [31:0] sb_busy;
    logic [2:0]  q_count;
    logic        idle;
    logic        err_spurious;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] instr;
        logic        drain;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    carrd_issue_ctrl #(
        .NUM_FU      (4),
        .QUEUE_DEPTH (4),
        .NUM_VREGS   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_instr    (enq_instr),
        .enq_fu       (enq_fu),
        .enq_drain    (enq_drain),
        .enq_vd       (enq_vd),
        .enq_vs1      (enq_vs1),
        .enq_vs2      (enq_vs2),
        .enq_use_vs1  (enq_use_vs1),
        .enq_use_vs2  (enq_use_vs2),
        .enq_wr_vd    (enq_wr_vd),
        .enq_nregs    (enq_nregs),
        .fu_done      (fu_done),
        .iss_valid    (iss_valid),
        .iss_instr    (iss_instr),
        .iss_drain    (iss_drain),
        .sb_busy      (sb_busy),
        .q_count      (q_count),
        .idle         (idle),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on a miss reports tag, observed, expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic issue_entry_t mkOp(input logic [31:0] instr, input fu_idx_e fu,
                                          input logic [4:0] vd, input logic [4:0] vs1,
                                          input logic [4:0] vs2, input logic u1, input logic u2,
                                          input logic wr, input logic [2:0] n);
        issue_entry_t e;
        e.instr = instr; e.fu = fu; e.drain = 1'b0;
        e.vd = vd; e.vs1 = vs1; e.vs2 = vs2;
        e.use_vs1 = u1; e.use_vs2 = u2; e.wr_vd = wr; e.nregs = n;
        return e;
    endfunction

    function automatic issue_entry_t mkDrain(input logic [31:0] instr);
        issue_entry_t e;
        e = mkOp(instr, FU_LANES, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1);
        e.drain = 1'b1;
        return e;
    endfunction

    // Offer one entry for one cycle, starting and ending on a falling edge.
    // The expected issue is queued only if the FIFO had room at that edge.
    task automatic applyStimulus(input issue_entry_t e);
        logic accepted;
        exp_t x;
        enq_instr   = e.instr;
        enq_fu      = e.fu;
        enq_drain   = e.drain;
        enq_vd      = e.vd;
        enq_vs1     = e.vs1;
        enq_vs2     = e.vs2;
        enq_use_vs1 = e.use_vs1;
        enq_use_vs2 = e.use_vs2;
        enq_wr_vd   = e.wr_vd;
        enq_nregs   = e.nregs;
        enq_valid   = 1'b1;
        accepted    = enq_ready;
        @(negedge clk);
        enq_valid = 1'b0;
        if (accepted) begin
            x.valid = e.drain ? 4'b0000 : (4'b0001 << e.fu);
            x.instr = e.instr;
            x.drain = e.drain;
            sbQ.push_back(x);
        end
    endtask

    task automatic pulseDone(input logic [3:0] mask);
        fu_done = mask;
        @(negedge clk);
        fu_done = 4'b0000;
    endtask

    // Every issue or drain pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && (iss_valid != 4'b0000 || iss_drain)) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_issue", {59'd0, iss_drain, iss_valid}, 64'd0);
            end else begin
                x = sbQ.pop_front();
                checkOutput("sb_iss_valid", iss_valid, x.valid);
                checkOutput("sb_iss_instr", iss_instr, x.instr);
                checkOutput("sb_iss_drain", iss_drain, x.drain);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_instr = '0; enq_fu = '0; enq_drain = 1'b0;
        enq_vd = '0; enq_vs1 = '0; enq_vs2 = '0; enq_use_vs1 = 1'b0; enq_use_vs2 = 1'b0;
        enq_wr_vd = 1'b0; enq_nregs = 3'd1; fu_done = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_idle",      idle,         1'b1);
        checkOutput("rst_q_count",   q_count,      3'd0);
        checkOutput("rst_enq_ready", enq_ready,    1'b1);
        checkOutput("rst_iss_valid", iss_valid,    4'b0000);
        checkOutput("rst_iss_instr", iss_instr,    32'd0);
        checkOutput("rst_iss_drain", iss_drain,    1'b0);
        checkOutput("rst_sb_busy",   sb_busy,      32'd0);
        checkOutput("rst_err",       err_spurious, 1'b0);
        rst = 1'b0;

        // Basic issue and retire on the lanes unit.
        applyStimulus(mkOp(32'h0000_1001, FU_LANES, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 3'd1));
        checkOutput("t1_latency_none", iss_valid, 4'b0000);
        checkOutput("t1_q_count",      q_count,   3'd1);
        @(negedge clk);
        checkOutput("t1_issue",   iss_valid, 4'b0001);
        checkOutput("t1_sb_set",  sb_busy,   32'h0000_0010);
        checkOutput("t1_busy",    idle,      1'b0);
        pulseDone(4'b0001);
        checkOutput("t1_sb_clear", sb_busy, 32'd0);
        checkOutput("t1_idle",     idle,    1'b1);

        // Read-after-write: reduction reads v4 while lanes writes it.
        applyStimulus(mkOp(32'h0000_2001, FU_LANES, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1));
        applyStimulus(mkOp(32'h0000_2002, FU_RED,   5'd6, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 3'd1));
        checkOutput("t2_add_issue", iss_valid, 4'b0001);
        @(negedge clk);
        checkOutput("t2_raw_hold0", iss_valid, 4'b0000);
        checkOutput("t2_q_held",    q_count,   3'd1);
        @(negedge clk);
        checkOutput("t2_raw_hold1", iss_valid, 4'b0000);
        pulseDone(4'b0001);
        checkOutput("t2_no_bypass", iss_valid, 4'b0000);
        @(negedge clk);
        checkOutput("t2_red_issue", iss_valid, 4'b0010);
        checkOutput("t2_red_sb",    sb_busy,   32'h0000_0040);
        pulseDone(4'b0010);
        checkOutput("t2_idle", idle, 1'b1);

        // Register groups, including truncation at the top of the file.
        applyStimulus(mkOp(32'h0000_3001, FU_LANES, 5'd8,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 3'd4));
        applyStimulus(mkOp(32'h0000_3002, FU_SLDU,  5'd30, 5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 3'd4));
        checkOutput("t3_grp8_sb", sb_busy, 32'h0000_0F00);
        applyStimulus(mkOp(32'h0000_3003, FU_RED,   5'd0,  5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 3'd1));
        checkOutput("t3_sldu_issue", iss_valid, 4'b0100);
        checkOutput("t3_grp30_sb",   sb_busy,   32'hC000_0F00);
        @(negedge clk);
        checkOutput("t3_vs1_stall", iss_valid, 4'b0000);
        pulseDone(4'b0001);
        checkOutput("t3_after_retire_sb", sb_busy,   32'hC000_0000);
        checkOutput("t3_still_stalled",   iss_valid, 4'b0000);
        @(negedge clk);
        checkOutput("t3_red_issue", iss_valid, 4'b0010);
        checkOutput("t3_red_no_wr", sb_busy,   32'hC000_0000);
        pulseDone(4'b0110);
        checkOutput("t3_multi_retire", sb_busy, 32'd0);
        checkOutput("t3_idle",         idle,    1'b1);

        // Fill the queue behind a busy lanes unit; nregs=3 behaves as one reg.
        applyStimulus(mkOp(32'h0000_4000, FU_LANES, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd3));
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(mkOp(32'h0000_4000 + i, FU_LANES, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1));
            if (i == 1) checkOutput("t4_n3_sb", sb_busy, 32'h0000_1000);
        end
        checkOutput("t4_full_count", q_count,   3'd4);
        checkOutput("t4_full_ready", enq_ready, 1'b0);
        applyStimulus(mkOp(32'h0000_4005, FU_LANES, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1));
        checkOutput("t4_reject_count", q_count, 3'd4);
        pulseDone(4'b0001);
        checkOutput("t4_ready_no_bypass", enq_ready, 1'b0);
        @(negedge clk);
        checkOutput("t4_slot_freed", enq_ready, 1'b1);
        checkOutput("t4_count3",     q_count,   3'd3);
        applyStimulus(mkOp(32'h0000_4005, FU_LANES, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1));
        checkOutput("t4_refill", q_count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            pulseDone(4'b0001);
            @(negedge clk);
        end
        pulseDone(4'b0001);
        checkOutput("t4_empty", q_count, 3'd0);
        checkOutput("t4_idle",  idle,    1'b1);

        // Drain waits for the slide unit to finish, then lets younger work go.
        applyStimulus(mkOp(32'h0000_5001, FU_SLDU, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2));
        applyStimulus(mkDrain(32'h0000_5002));
        checkOutput("t5_sldu_issue", iss_valid, 4'b0100);
        checkOutput("t5_grp2_sb",    sb_busy,   32'h0003_0000);
        applyStimulus(mkOp(32'h0000_5003, FU_LANES, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1));
        checkOutput("t5_drain_wait0", iss_drain, 1'b0);
        @(negedge clk);
        checkOutput("t5_drain_wait1", iss_drain, 1'b0);
        checkOutput("t5_younger_held", iss_valid, 4'b0000);
        pulseDone(4'b0100);
        checkOutput("t5_drain_no_bypass", iss_drain, 1'b0);
        @(negedge clk);
        checkOutput("t5_drain_pulse", iss_drain, 1'b1);
        checkOutput("t5_drain_instr", iss_instr, 32'h0000_5002);
        checkOutput("t5_drain_no_fu", iss_valid, 4'b0000);
        @(negedge clk);
        checkOutput("t5_drain_one_cycle", iss_drain, 1'b0);
        checkOutput("t5_younger_issue",   iss_valid, 4'b0001);
        pulseDone(4'b0001);
        checkOutput("t5_idle", idle, 1'b1);

        // Spurious done, then reset with work queued and in flight.
        pulseDone(4'b1000);
        checkOutput("t6_spurious_set", err_spurious, 1'b1);
        @(negedge clk);
        checkOutput("t6_spurious_sticky", err_spurious, 1'b1);
        checkOutput("t6_spurious_idle",   idle,         1'b1);
        applyStimulus(mkOp(32'h0000_6000, FU_LSU, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1));
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(mkOp(32'h0000_6000 + i, FU_LSU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1));
        end
        checkOutput("t6_queued3", q_count, 3'd3);
        checkOutput("t6_sb_lsu",  sb_busy, 32'h0010_0000);
        rst     = 1'b1;
        fu_done = 4'b1000;
        sbQ.delete();
        @(negedge clk);
        checkOutput("t6_rst_idle",    idle,         1'b1);
        checkOutput("t6_rst_q_count", q_count,      3'd0);
        checkOutput("t6_rst_err",     err_spurious, 1'b0);
        checkOutput("t6_rst_sb",      sb_busy,      32'd0);
        rst     = 1'b0;
        fu_done = 4'b0000;
        applyStimulus(mkOp(32'h0000_6100, FU_LSU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1));
        @(negedge clk);
        checkOutput("t6_post_rst_issue", iss_valid, 4'b1000);
        pulseDone(4'b1000);
        checkOutput("t6_post_rst_err",  err_spurious, 1'b0);
        checkOutput("t6_post_rst_idle", idle,         1'b1);

        @(negedge clk);
        checkOutput("sb_drained", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
